dmem_access_arbiter: RTL and testbench

- Shares the single-port data memory between three requesters: the pipeline MEM stage (CPU), the user debug port, and the EDC error-injection port.
- Serialises accesses through a small issue/wait/capture FSM and returns read data with a one-cycle ack.
- Generates cpu_stall, which feeds the pipeline-wide isCacheStall freeze while a CPU access is outstanding.
- Sits between the MEM-stage memory interface and the data RAM.

---
 rtl/dmem_arb_pkg.sv | 26 ++
 rtl/dmem_arb_prio_sel.sv | 31 +++
 rtl/dmem_access_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_dmem_access_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory access arbiter.
// State and owner encodings are used by the arbiter top and its priority selector.
package dmem_arb_pkg;

  localparam int DEF_ADDR_W        = 13;
  localparam int DEF_DATA_W        = 32;
  localparam int DEF_MEM_LAT       = 1;
  localparam int DEF_USER_MAX_WAIT = 8;

  localparam int N_REQ = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_CAPTURE = 2'd3
  } state_e;

  // Owner codes double as bit indices into the request/grant vectors.
  typedef enum logic [1:0] {
    OWN_CPU  = 2'd0,
    OWN_ERR  = 2'd1,
    OWN_USER = 2'd2
  } owner_e;

endpackage

// File: rtl/dmem_arb_prio_sel.sv
// Fixed-priority requester select (CPU > ERR > USER) with a starvation
// override that lets an eligible USER request win over everything.
module dmem_arb_prio_sel
  import dmem_arb_pkg::*;
(
  input  logic [N_REQ-1:0] i_elig,
  input  logic             i_boost,
  output logic [N_REQ-1:0] o_grant,
  output owner_e           o_owner
);

  // NOTE: every output gets a default before the branches so no latch is inferred.
  always_comb begin
    o_grant = '0;
    o_owner = OWN_CPU;
    if (i_boost && i_elig[OWN_USER]) begin
      o_grant[OWN_USER] = 1'b1;
      o_owner           = OWN_USER;
    end else if (i_elig[OWN_CPU]) begin
      o_grant[OWN_CPU] = 1'b1;
      o_owner          = OWN_CPU;
    end else if (i_elig[OWN_ERR]) begin
      o_grant[OWN_ERR] = 1'b1;
      o_owner          = OWN_ERR;
    end else if (i_elig[OWN_USER]) begin
      o_grant[OWN_USER] = 1'b1;
      o_owner           = OWN_USER;
    end
  end

endmodule

// File: rtl/dmem_access_arbiter.sv
// Serialises CPU, EDC and user-debug accesses onto the single-port data RAM.
// Optional perf counters are compiled in with `define DMEM_ARB_PERF_EN.
module dmem_access_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W        = DEF_ADDR_W,
  parameter int DATA_W        = DEF_DATA_W,
  parameter int MEM_LAT       = DEF_MEM_LAT,
  parameter int USER_MAX_WAIT = DEF_USER_MAX_WAIT
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_din,
  output logic [DATA_W-1:0] cpu_dout,
  output logic              cpu_ack,
  output logic              cpu_stall,
  input  logic              user_req,
  input  logic              user_we,
  input  logic [ADDR_W-1:0] user_addr,
  input  logic [DATA_W-1:0] user_din,
  output logic [DATA_W-1:0] user_dout,
  output logic              user_ack,
  input  logic              err_req,
  input  logic              err_we,
  input  logic [ADDR_W-1:0] err_addr,
  input  logic [DATA_W-1:0] err_din,
  output logic [DATA_W-1:0] err_dout,
  output logic              err_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [15:0]       perf_user_boost_cnt
`endif
);

  localparam int LW       = (MEM_LAT > 2) ? $clog2(MEM_LAT - 1) : 1;
  localparam int LAT_LOAD = (MEM_LAT > 1) ? (MEM_LAT - 2) : 0;
  localparam int CW       = $clog2(USER_MAX_WAIT + 1);

  state_e            r_state;
  owner_e            r_owner;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_din;
  logic [LW-1:0]     r_lat_cnt;
  logic [CW-1:0]     r_user_wait_cnt;
  logic              r_cpu_ack;
  logic              r_err_ack;
  logic              r_user_ack;
  logic [DATA_W-1:0] r_cpu_dout;
  logic [DATA_W-1:0] r_err_dout;
  logic [DATA_W-1:0] r_user_dout;

  logic [N_REQ-1:0]  w_elig;
  logic [N_REQ-1:0]  w_grant;
  owner_e            w_owner;
  logic              w_any;
  logic              w_boost;
  logic              w_arb;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_din;

  // A requester whose ack is high this cycle is masked so it is not granted twice.
  assign w_elig[OWN_CPU]  = cpu_req  & ~r_cpu_ack;
  assign w_elig[OWN_ERR]  = err_req  & ~r_err_ack;
  assign w_elig[OWN_USER] = user_req & ~r_user_ack;
  assign w_any   = |w_elig;
  assign w_boost = (r_user_wait_cnt == CW'(USER_MAX_WAIT));
  assign w_arb   = (r_state == ST_IDLE) && w_any;

  dmem_arb_prio_sel u_prio_sel (
    .i_elig  (w_elig),
    .i_boost (w_boost),
    .o_grant (w_grant),
    .o_owner (w_owner)
  );

  always_comb begin
    w_sel_we   = cpu_we;
    w_sel_addr = cpu_addr;
    w_sel_din  = cpu_din;
    case (w_owner)
      OWN_ERR: begin
        w_sel_we   = err_we;
        w_sel_addr = err_addr;
        w_sel_din  = err_din;
      end
      OWN_USER: begin
        w_sel_we   = user_we;
        w_sel_addr = user_addr;
        w_sel_din  = user_din;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_owner   <= OWN_CPU;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_din     <= '0;
      r_lat_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_owner <= w_owner;
            r_we    <= w_sel_we;
            r_addr  <= w_sel_addr;
            r_din   <= w_sel_din;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (MEM_LAT > 1) begin
            r_lat_cnt <= LW'(LAT_LOAD);
            r_state   <= ST_WAIT;
          end else begin
            r_state <= ST_CAPTURE;
          end
        end
        ST_WAIT: begin
          if (r_lat_cnt == '0) r_state <= ST_CAPTURE;
          else                 r_lat_cnt <= r_lat_cnt - 1'b1;
        end
        ST_CAPTURE: r_state <= ST_IDLE;
        default:    r_state <= ST_IDLE;
      endcase
    end
  end

  // Read data is captured into the owner's register even for writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cpu_ack   <= 1'b0;
      r_err_ack   <= 1'b0;
      r_user_ack  <= 1'b0;
      r_cpu_dout  <= '0;
      r_err_dout  <= '0;
      r_user_dout <= '0;
    end else begin
      r_cpu_ack  <= (r_state == ST_CAPTURE) && (r_owner == OWN_CPU);
      r_err_ack  <= (r_state == ST_CAPTURE) && (r_owner == OWN_ERR);
      r_user_ack <= (r_state == ST_CAPTURE) && (r_owner == OWN_USER);
      if (r_state == ST_CAPTURE) begin
        case (r_owner)
          OWN_CPU:  r_cpu_dout  <= mem_dout;
          OWN_ERR:  r_err_dout  <= mem_dout;
          OWN_USER: r_user_dout <= mem_dout;
          default:  ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_user_wait_cnt <= '0;
    end else if (!user_req) begin
      r_user_wait_cnt <= '0;
    end else if (w_arb) begin
      if (w_grant[OWN_USER])
        r_user_wait_cnt <= '0;
      else if (w_elig[OWN_USER] && !w_boost)
        r_user_wait_cnt <= r_user_wait_cnt + 1'b1;
    end
  end

  assign mem_en    = (r_state == ST_ISSUE);
  assign mem_we    = mem_en & r_we;
  assign mem_addr  = mem_en ? r_addr : '0;
  assign mem_din   = mem_en ? r_din  : '0;

  assign cpu_ack   = r_cpu_ack;
  assign err_ack   = r_err_ack;
  assign user_ack  = r_user_ack;
  assign cpu_dout  = r_cpu_dout;
  assign err_dout  = r_err_dout;
  assign user_dout = r_user_dout;
  assign cpu_stall = cpu_req & ~r_cpu_ack;

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] r_perf_stall_cnt;
  logic [15:0] r_perf_boost_cnt;
  logic        w_boost_grant;

  assign w_boost_grant = w_arb && w_boost && w_grant[OWN_USER];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_stall_cnt <= '0;
      r_perf_boost_cnt <= '0;
    end else begin
      if (cpu_stall && (r_perf_stall_cnt != '1))
        r_perf_stall_cnt <= r_perf_stall_cnt + 1'b1;
      if (w_boost_grant && (r_perf_boost_cnt != '1))
        r_perf_boost_cnt <= r_perf_boost_cnt + 1'b1;
    end
  end

  assign perf_stall_cnt      = r_perf_stall_cnt;
  assign perf_user_boost_cnt = r_perf_boost_cnt;
`endif

endmodule

// File: tb/tb_dmem_access_arbiter.sv
// Directed bench for dmem_access_arbiter: one instance at MEM_LAT=1/USER_MAX_WAIT=2,
// a second at MEM_LAT=3 for the mid-transaction reset case.
module tb_dmem_access_arbiter;

  localparam int AW = 13;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- instance 1 (MEM_LAT=1) ----------------
  logic          rst;
  logic          cpu_req, cpu_we, user_req, user_we, err_req, err_we;
  logic [AW-1:0] cpu_addr, user_addr, err_addr;
  logic [DW-1:0] cpu_din, user_din, err_din;
  logic [DW-1:0] cpu_dout, user_dout, err_dout;
  logic          cpu_ack, cpu_stall, user_ack, err_ack;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din, mem_dout;
`ifdef DMEM_ARB_PERF_EN
  logic [31:0]   perf_stall_cnt;
  logic [15:0]   perf_user_boost_cnt;
`endif

  dmem_access_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1), .USER_MAX_WAIT(2)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
    .user_req(user_req), .user_we(user_we), .user_addr(user_addr), .user_din(user_din),
    .user_dout(user_dout), .user_ack(user_ack),
    .err_req(err_req), .err_we(err_we), .err_addr(err_addr), .err_din(err_din),
    .err_dout(err_dout), .err_ack(err_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout)
`ifdef DMEM_ARB_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_user_boost_cnt(perf_user_boost_cnt)
`endif
  );

  // Single-port RAM, one-cycle registered read (read-before-write).
  logic [DW-1:0] mem1 [0:(1<<AW)-1];
  logic [DW-1:0] rd1;
  always @(posedge clk) begin
    if (mem_en) begin
      rd1 = mem1[mem_addr];
      if (mem_we) mem1[mem_addr] = mem_din;
      mem_dout <= rd1;
    end
  end

  // ---------------- instance 3 (MEM_LAT=3) ----------------
  logic          rst3;
  logic          cpu_req3;
  logic [AW-1:0] cpu_addr3;
  logic [DW-1:0] cpu_dout3, user_dout3, err_dout3;
  logic          cpu_ack3, cpu_stall3, user_ack3, err_ack3;
  logic          mem_en3, mem_we3;
  logic [AW-1:0] mem_addr3;
  logic [DW-1:0] mem_din3, mem_dout3;
  logic          tie0 = 1'b0;
  logic [AW-1:0] tie_a = '0;
  logic [DW-1:0] tie_d = '0;
`ifdef DMEM_ARB_PERF_EN
  logic [31:0]   perf_stall_cnt3;
  logic [15:0]   perf_user_boost_cnt3;
`endif

  dmem_access_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3), .USER_MAX_WAIT(8)) dut3 (
    .clk(clk), .rst(rst3),
    .cpu_req(cpu_req3), .cpu_we(tie0), .cpu_addr(cpu_addr3), .cpu_din(tie_d),
    .cpu_dout(cpu_dout3), .cpu_ack(cpu_ack3), .cpu_stall(cpu_stall3),
    .user_req(tie0), .user_we(tie0), .user_addr(tie_a), .user_din(tie_d),
    .user_dout(user_dout3), .user_ack(user_ack3),
    .err_req(tie0), .err_we(tie0), .err_addr(tie_a), .err_din(tie_d),
    .err_dout(err_dout3), .err_ack(err_ack3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_din(mem_din3),
    .mem_dout(mem_dout3)
`ifdef DMEM_ARB_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt3), .perf_user_boost_cnt(perf_user_boost_cnt3)
`endif
  );

  // Three-cycle read pipeline: data issued at T1 is on mem_dout3 at T4.
  logic [DW-1:0] mem3 [0:(1<<AW)-1];
  logic [DW-1:0] p0, p1;
  always @(posedge clk) begin
    if (mem_en3) p0 <= mem3[mem_addr3];
    p1        <= p0;
    mem_dout3 <= p1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    mem1[13'h010] = 32'hDEADBEEF;
    mem1[13'h020] = 32'h11112222;
    mem1[13'h030] = 32'h33334444;
    mem3[13'h010] = 32'hCAFEF00D;

    rst = 1'b0; rst3 = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h010; cpu_din = '0;
    err_req = 1'b1; err_we = 1'b0; err_addr = 13'h020; err_din = '0;
    user_req = 1'b1; user_we = 1'b0; user_addr = 13'h030; user_din = '0;
    cpu_req3 = 1'b0; cpu_addr3 = '0;
    mem_dout = '0; p0 = '0; p1 = '0; mem_dout3 = '0;

    // Reset held with every request high.
    repeat (3) step();
    check("rst_cpu_ack",   cpu_ack,   0);
    check("rst_err_ack",   err_ack,   0);
    check("rst_user_ack",  user_ack,  0);
    check("rst_mem_en",    mem_en,    0);
    check("rst_cpu_dout",  cpu_dout,  0);
    check("rst_err_dout",  err_dout,  0);
    check("rst_user_dout", user_dout, 0);
    check("rst_mem_addr",  mem_addr,  0);

    // Release: T0 with all three requesting -> CPU, ERR, USER.
    rst = 1'b1; rst3 = 1'b1;
    check("t0_stall", cpu_stall, 1);
    step();  // T1
    check("t1_mem_en",   mem_en,   1);
    check("t1_mem_addr", mem_addr, 32'h010);
    check("t1_mem_we",   mem_we,   0);
    step();  // T2
    check("t2_mem_en", mem_en,    0);
    check("t2_stall",  cpu_stall, 1);
    check("t2_ack",    cpu_ack,   0);
    step();  // T3
    check("t3_cpu_ack",  cpu_ack,  1);
    check("t3_cpu_dout", cpu_dout, 32'hDEADBEEF);
    check("t3_stall",    cpu_stall, 0);
    cpu_req = 1'b0;
    step();  // T4: ERR, not a second CPU grant
    check("t4_mem_addr", mem_addr, 32'h020);
    check("t4_mem_en",   mem_en,   1);
    check("t4_cpu_ack",  cpu_ack,  0);
    repeat (2) step();  // T6
    check("t6_err_ack",  err_ack,  1);
    check("t6_err_dout", err_dout, 32'h11112222);
    err_req = 1'b0;
    step();  // T7
    check("t7_mem_addr", mem_addr, 32'h030);
    repeat (2) step();  // T9
    check("t9_user_ack",  user_ack,  1);
    check("t9_user_dout", user_dout, 32'h33334444);
    check("t9_cpu_dout_held", cpu_dout, 32'hDEADBEEF);
    user_req = 1'b0;
    step();  // T10
    check("t10_user_ack", user_ack, 0);
    check("t10_mem_en",   mem_en,   0);

    // Starvation: CPU held high continuously, ERR and USER also requesting.
    repeat (2) step();
    cpu_req = 1'b1; cpu_addr = 13'h010;
    err_req = 1'b1; err_addr = 13'h020;
    user_req = 1'b1; user_addr = 13'h030;
    step();  // S1
    check("s1_cpu_grant", mem_addr, 32'h010);
    repeat (2) step();  // S3
    check("s3_cpu_ack", cpu_ack, 1);
    step();  // S4
    check("s4_err_grant", mem_addr, 32'h020);
    repeat (2) step();  // S6
    check("s6_err_ack", err_ack, 1);
    step();  // S7: third arbitration goes to USER despite CPU
    check("s7_user_boost", mem_addr, 32'h030);
    repeat (2) step();  // S9
    check("s9_user_ack", user_ack, 1);
    step();  // S10
    check("s10_cpu_grant", mem_addr, 32'h010);
    repeat (2) step();  // S12
    check("s12_cpu_ack", cpu_ack, 1);
    step();  // S13: counter was cleared, so ERR beats USER
    check("s13_cnt_cleared", mem_addr, 32'h020);
    cpu_req = 1'b0; err_req = 1'b0; user_req = 1'b0;
    repeat (2) step();  // S15
    check("s15_err_ack_after_drop", err_ack, 1);
    step();
`ifdef DMEM_ARB_PERF_EN
    check("perf_boost_cnt", perf_user_boost_cnt, 2);
`endif

    // Write whose requester drops req during ISSUE.
    err_req = 1'b1; err_we = 1'b1; err_addr = 13'h040; err_din = 32'h5A5A5A5A;
    step();  // E1
    check("e1_mem_en",  mem_en,  1);
    check("e1_mem_we",  mem_we,  1);
    check("e1_mem_din", mem_din, 32'h5A5A5A5A);
    err_req = 1'b0; err_we = 1'b0; err_din = 32'hFFFFFFFF;
    repeat (2) step();  // E3
    check("e3_err_ack", err_ack, 1);
    step();  // E4
    check("e4_err_ack_once", err_ack, 0);
    check("e4_mem_en",       mem_en,  0);
    cpu_req = 1'b1; cpu_addr = 13'h040;
    repeat (3) step();
    check("rb_cpu_ack",  cpu_ack,  1);
    check("rb_cpu_dout", cpu_dout, 32'h5A5A5A5A);
    cpu_req = 1'b0;
    step();

    // MEM_LAT=3: reset during ISSUE aborts the access.
    cpu_req3 = 1'b1; cpu_addr3 = 13'h010;
    step();  // R1
    check("l3_issue_mem_en", mem_en3, 1);
    rst3 = 1'b0;
    #1;
    check("l3_rst_mem_en_now", mem_en3, 0);
    step();
    check("l3_rst_no_ack_a", cpu_ack3, 0);
    step();
    check("l3_rst_no_ack_b", cpu_ack3, 0);
    check("l3_rst_mem_en",   mem_en3,  0);
    rst3 = 1'b1;  // new R0, FSM must be idle
    step();  // R1
    check("l3_r1_mem_en", mem_en3, 1);
    step();  // R2
    check("l3_r2_mem_en", mem_en3, 0);
    repeat (2) step();  // R4
    check("l3_r4_no_ack", cpu_ack3,   0);
    check("l3_r4_stall",  cpu_stall3, 1);
    step();  // R5
    check("l3_r5_ack",  cpu_ack3,  1);
    check("l3_r5_dout", cpu_dout3, 32'hCAFEF00D);
`ifdef DMEM_ARB_PERF_EN
    check("l3_perf_stall", perf_stall_cnt3, 5);
    check("l3_perf_boost", perf_user_boost_cnt3, 0);
`endif
    cpu_req3 = 1'b0;
    step();
    check("l3_r6_ack", cpu_ack3, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
